mac_dot_scheduler: RTL

- Sequences one `MAC_pipeline` instance to compute a double-precision dot product, sum over i < K of a_i*b_i, from a streamed operand pair sequence.
- Hides the MAC's accumulate latency by interleaving SLOTS independent partial sums round-robin.
- Once all pairs are issued, it reduces the partial sums through the same MAC using b = 1.0.
- Sits between the matrix-tile operand fetch logic and the MAC datapath; one job runs at a time.

---
 rtl/mac_dot_scheduler.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/mac_dot_scheduler.sv
// mac_dot_scheduler
//   Drives one external MAC pipeline to compute a double-precision dot
//   product sum(a_i * b_i) over k_len streamed operand pairs. Consecutive
//   pairs rotate over SLOTS independent partial sums, which hides the MAC's
//   accumulate latency. After the last pair the partial sums are folded
//   together serially through the same MAC, with b = 1.0.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start, k_len        launch a job with k_len pairs (sampled only in IDLE)
//   in_valid/in_ready   operand pair handshake; in_a / in_b carry the pair
//   busy, done          job in progress / one-cycle completion pulse
//   result, err         dot product (held until next done) / sticky job error
//   mac_valid           MAC issue strobe, with operands on mac_ta / mac_tb
//   mac_c               addend, presented C_LAT cycles after the issue
//   mac_res             MAC result, valid with mac_store_valid
//   mac_store_valid     MAC result strobe
//   mac_error           MAC exponent-range error
module mac_dot_scheduler #(
  parameter int MAC_LAT = 11,
  parameter int C_LAT   = 4,
  parameter int SLOTS   = 8,
  parameter int KW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_a,
  input  logic [63:0]   in_b,
  output logic          busy,
  output logic          done,
  output logic [63:0]   result,
  output logic          err,
  output logic          mac_valid,
  output logic [63:0]   mac_ta,
  output logic [63:0]   mac_tb,
  output logic [63:0]   mac_c,
  input  logic [63:0]   mac_res,
  input  logic          mac_store_valid,
  input  logic          mac_error
);

  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int UW = SW + 1;
  localparam int OW = $clog2(MAC_LAT + 2) + 1;
  localparam logic [63:0] ONE = 64'h3FF0000000000000;

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, REDUCE, FIN} state_t;

  // One entry per MAC issue, travelling alongside the operation.
  // kind = 1 marks a reduction step (addend and result live in acc).
  typedef struct packed {
    logic          valid;
    logic          kind;
    logic [SW-1:0] slot;
  } tag_t;

  state_t          state, state_next;
  logic [KW-1:0]   k_reg;
  logic [KW-1:0]   issued;
  logic [SW-1:0]   slot_idx;
  logic [UW-1:0]   used;
  logic [SW-1:0]   red_idx;
  logic            red_wait;
  logic [OW-1:0]   outstanding;
  logic [63:0]     acc;
  logic [63:0]     slot_data [SLOTS];
  logic [SLOTS-1:0] slot_valid;

  logic            mac_kind;
  logic [SW-1:0]   mac_slot;
  tag_t            line [0:MAC_LAT];
  tag_t            c_tap, wb_tap;

  logic            accept;
  logic            red_issue;
  logic            issue_now;
  logic            red_last;

  assign busy      = (state != IDLE);
  assign in_ready  = (state == ACCUM) && (issued != k_reg);
  assign accept    = in_valid && in_ready;
  assign red_issue = (state == REDUCE) && !red_wait;
  assign issue_now = accept || red_issue;
  assign red_last  = (UW'(red_idx) == used - UW'(1));

  assign c_tap  = line[C_LAT];
  assign wb_tap = line[MAC_LAT];

  // Issue delay line: stage gi holds the tag of the issue made gi cycles ago.
  assign line[0] = '{valid: mac_valid, kind: mac_kind, slot: mac_slot};

  genvar gi;
  generate
    for (gi = 1; gi <= MAC_LAT; gi++) begin : g_delay
      always_ff @(posedge clk) begin
        if (!rst_n) line[gi] <= '0;
        else        line[gi] <= line[gi-1];
      end
    end
  endgenerate

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = (k_len == '0) ? FIN : ACCUM;
      ACCUM:  if (issued == k_reg) state_next = DRAIN;
      DRAIN:  if (outstanding == '0) state_next = (used == UW'(1)) ? FIN : REDUCE;
      REDUCE: if (wb_tap.valid && wb_tap.kind && red_last) state_next = FIN;
      FIN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Addend selection. A slot read in the same cycle that slot's previous
  // result is written back takes mac_res directly; the slot register still
  // holds the older value at that point.
  always_comb begin
    mac_c = 64'h0;
    if (c_tap.valid) begin
      if (c_tap.kind)
        mac_c = acc;
      else if (wb_tap.valid && !wb_tap.kind && (wb_tap.slot == c_tap.slot))
        mac_c = mac_res;
      else if (slot_valid[c_tap.slot])
        mac_c = slot_data[c_tap.slot];
    end
  end

  // Partial-sum storage; contents are qualified by slot_valid.
  always_ff @(posedge clk) begin
    if (wb_tap.valid && !wb_tap.kind)
      slot_data[wb_tap.slot] <= mac_res;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      k_reg       <= '0;
      issued      <= '0;
      slot_idx    <= '0;
      used        <= '0;
      red_idx     <= '0;
      red_wait    <= 1'b0;
      outstanding <= '0;
      acc         <= 64'h0;
      slot_valid  <= '0;
      done        <= 1'b0;
      result      <= 64'h0;
      err         <= 1'b0;
      mac_valid   <= 1'b0;
      mac_kind    <= 1'b0;
      mac_slot    <= '0;
      mac_ta      <= 64'h0;
      mac_tb      <= 64'h0;
    end else begin
      state     <= state_next;
      done      <= 1'b0;
      mac_valid <= issue_now;
      mac_kind  <= red_issue;
      mac_slot  <= accept ? slot_idx : '0;
      if (accept) begin
        mac_ta <= in_a;
        mac_tb <= in_b;
      end else if (red_issue) begin
        mac_ta <= slot_data[red_idx];
        mac_tb <= ONE;
      end

      case ({issue_now, wb_tap.valid})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase

      case (state)
        IDLE: if (start) begin
          k_reg      <= k_len;
          issued     <= '0;
          slot_idx   <= '0;
          slot_valid <= '0;
          acc        <= 64'h0;
          err        <= 1'b0;
          used       <= (k_len < KW'(SLOTS)) ? UW'(k_len) : UW'(SLOTS);
        end
        ACCUM: if (accept) begin
          issued   <= issued + KW'(1);
          slot_idx <= (slot_idx == SW'(SLOTS - 1)) ? '0 : slot_idx + SW'(1);
        end
        DRAIN: if (outstanding == '0) begin
          acc      <= slot_data[0];
          red_idx  <= SW'(1);
          red_wait <= 1'b0;
        end
        REDUCE: if (red_issue) red_wait <= 1'b1;
        FIN: begin
          result <= acc;
          done   <= 1'b1;
        end
        default: ;
      endcase

      if (wb_tap.valid) begin
        if (wb_tap.kind) begin
          acc      <= mac_res;
          red_idx  <= red_idx + SW'(1);
          red_wait <= 1'b0;
        end else begin
          slot_valid[wb_tap.slot] <= 1'b1;
        end
      end

      // Errors only count while a job is running, so stray results from
      // issues made before a reset cannot pollute the next job.
      if (busy) begin
        if (wb_tap.valid && mac_error) err <= 1'b1;
        if (mac_store_valid != wb_tap.valid) err <= 1'b1;
      end
    end
  end

endmodule
